// File: rtl/pkt_store_pkg.sv
// pkt_store_pkg: shared types and constants for the packet store.
//   state_e     receive FSM states (IDLE, RECV, DROP)
//   LEN_W       width of packet lengths and byte counters
//   ETH_BYTE_W  width of one decoded byte
//   DEF_*_LEN   default accepted packet length limits
package pkt_store_pkg;

  localparam int unsigned LEN_W       = 11;
  localparam int unsigned ETH_BYTE_W  = 8;
  localparam int unsigned DEF_MAX_LEN = 1518;
  localparam int unsigned DEF_MIN_LEN = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_e;

endpackage

// File: rtl/pkt_desc_fifo.sv
// pkt_desc_fifo: small synchronous FIFO of committed packet lengths.
//   clk, n_rst     clock, asynchronous active-low reset
//   push/push_data append a length (caller never pushes when full)
//   pop            drop the head entry (caller never pops when empty)
//   head_c         length at the head, combinational from storage
//   full_c         all slots in use
//   count          entries held, registered
module pkt_desc_fifo
  import pkt_store_pkg::*;
#(
  parameter int unsigned SLOTS = 8,
  parameter int unsigned W     = LEN_W,
  parameter int unsigned CW    = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_c,
  output logic          full_c,
  output logic [CW-1:0] count
);

  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [W-1:0]  slots_q [SLOTS];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // Wrap explicitly so non-power-of-two slot counts also work.
  function automatic logic [IW-1:0] bump(input logic [IW-1:0] idx);
    return (idx == IW'(SLOTS - 1)) ? '0 : idx + IW'(1);
  endfunction

  assign head_c = slots_q[rd_idx];
  assign full_c = (count == CW'(SLOTS));

  // Length storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) slots_q[wr_idx] <= push_data;
  end

  // Indices and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= bump(wr_idx);
      if (pop)  rd_idx <= bump(rd_idx);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/pkt_store_fifo.sv
// pkt_store_fifo: single-clock circular byte store for decoded Ethernet
// packets. Bytes are written speculatively and only become readable when the
// packet ends cleanly with a legal length; everything else is rewound and
// reported on drop.
//   clk, n_rst                         clock, asynchronous active-low reset
//   wr_sop/wr_valid/wr_data/wr_eop/wr_abort  decoder-side write interface
//   r_en, r_data                       pop one byte, registered read data
//   empty, ready, full, drop           status, all registered
//   r_last, r_len, pkt_count           packet tracking, only when the macro
//                                      PKT_STORE_LEN_EN is defined
module pkt_store_fifo
  import pkt_store_pkg::*;
#(
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
  parameter int unsigned MIN_LEN   = DEF_MIN_LEN,
  parameter int unsigned PKT_SLOTS = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           wr_sop,
  input  logic                           wr_valid,
  input  logic [ETH_BYTE_W-1:0]          wr_data,
  input  logic                           wr_eop,
  input  logic                           wr_abort,
  input  logic                           r_en,
  output logic [ETH_BYTE_W-1:0]          r_data,
  output logic                           empty,
  output logic                           ready,
  output logic                           full,
`ifdef PKT_STORE_LEN_EN
  output logic                           r_last,
  output logic [LEN_W-1:0]               r_len,
  output logic [$clog2(PKT_SLOTS+1)-1:0] pkt_count,
`endif
  output logic                           drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  state_e                state, state_nxt;
  logic [PW-1:0]         rd_ptr, wr_commit, wr_spec;
  logic [PW-1:0]         rd_ptr_nxt, wr_commit_nxt, wr_spec_nxt, occ_c;
  logic [LEN_W-1:0]      len_cnt, len_cnt_nxt, len_eop_c;
  logic                  drop_nxt, ram_we_c, desc_push_c, desc_full_c;
  logic                  byte_bad_c, rd_fire_c;
  logic [ETH_BYTE_W-1:0] mem [DEPTH];

  assign rd_fire_c  = r_en && !empty;
  assign rd_ptr_nxt = rd_ptr + PW'(rd_fire_c);
  assign occ_c      = wr_spec - rd_ptr;
  // Length the packet would have if it ended this cycle.
  assign len_eop_c  = len_cnt + LEN_W'(wr_valid);
  // A byte that cannot be stored: RAM full or packet already at MAX_LEN.
  assign byte_bad_c = (occ_c == PW'(DEPTH)) || (len_cnt >= LEN_W'(MAX_LEN));

  // Receive FSM and speculative write pointer control.
  always_comb begin
    state_nxt     = state;
    wr_spec_nxt   = wr_spec;
    wr_commit_nxt = wr_commit;
    len_cnt_nxt   = len_cnt;
    drop_nxt      = 1'b0;
    ram_we_c      = 1'b0;
    desc_push_c   = 1'b0;
    unique case (state)
      IDLE, DROP: begin
        if (wr_sop) begin
          wr_spec_nxt = wr_commit;
          len_cnt_nxt = '0;
          state_nxt   = desc_full_c ? DROP : RECV;
          drop_nxt    = desc_full_c;
        end else if ((state == DROP) && (wr_eop || wr_abort)) begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (wr_abort) begin
          wr_spec_nxt = wr_commit;
          drop_nxt    = 1'b1;
          state_nxt   = IDLE;
        end else if (wr_sop) begin
          // New packet before an end: lose the old one and restart.
          wr_spec_nxt = wr_commit;
          len_cnt_nxt = '0;
          drop_nxt    = 1'b1;
          state_nxt   = desc_full_c ? DROP : RECV;
        end else if (wr_valid && byte_bad_c) begin
          wr_spec_nxt = wr_commit;
          drop_nxt    = 1'b1;
          state_nxt   = wr_eop ? IDLE : DROP;
        end else begin
          if (wr_valid) begin
            ram_we_c    = 1'b1;
            wr_spec_nxt = wr_spec + PW'(1);
            len_cnt_nxt = len_eop_c;
          end
          if (wr_eop) begin
            state_nxt = IDLE;
            if ((len_eop_c >= LEN_W'(MIN_LEN)) && (len_eop_c <= LEN_W'(MAX_LEN))) begin
              wr_commit_nxt = wr_spec_nxt;
              desc_push_c   = 1'b1;
            end else begin
              wr_spec_nxt = wr_commit;
              drop_nxt    = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte RAM write port.
  always_ff @(posedge clk) begin
    if (ram_we_c) mem[wr_spec[AW-1:0]] <= wr_data;
  end

  // State, pointers, read data and status flags from next-state values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_commit <= '0;
      wr_spec   <= '0;
      len_cnt   <= '0;
      r_data    <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_ptr    <= rd_ptr_nxt;
      wr_commit <= wr_commit_nxt;
      wr_spec   <= wr_spec_nxt;
      len_cnt   <= len_cnt_nxt;
      drop      <= drop_nxt;
      empty     <= (rd_ptr_nxt == wr_commit_nxt);
      full      <= ((wr_spec_nxt - rd_ptr_nxt) == PW'(DEPTH));
      if (rd_fire_c) r_data <= mem[rd_ptr[AW-1:0]];
    end
  end

`ifdef PKT_STORE_LEN_EN
  localparam int unsigned CW = $clog2(PKT_SLOTS + 1);

  logic [LEN_W-1:0] desc_head_c, head_cnt;
  logic             desc_pop_c, head_last_c;
  logic [CW-1:0]    cnt_nxt_c;

  pkt_desc_fifo #(
    .SLOTS (PKT_SLOTS),
    .W     (LEN_W),
    .CW    (CW)
  ) u_desc (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (desc_push_c),
    .push_data (len_eop_c),
    .pop       (desc_pop_c),
    .head_c    (desc_head_c),
    .full_c    (desc_full_c),
    .count     (pkt_count)
  );

  // head_cnt counts bytes already popped from the head packet.
  assign head_last_c = ((head_cnt + LEN_W'(1)) == desc_head_c);
  assign desc_pop_c  = rd_fire_c && head_last_c;
  assign cnt_nxt_c   = pkt_count + CW'(desc_push_c) - CW'(desc_pop_c);

  // Packet boundary tracking on the read side.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_cnt <= '0;
      r_last   <= 1'b0;
      r_len    <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= (cnt_nxt_c != '0);
      r_len <= (pkt_count != '0) ? desc_head_c : '0;
      if (rd_fire_c) begin
        r_last   <= head_last_c;
        head_cnt <= head_last_c ? '0 : head_cnt + LEN_W'(1);
      end
    end
  end
`else
  // Without descriptors a new packet is never blocked.
  assign desc_full_c = 1'b0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ready <= 1'b0;
    else        ready <= (rd_ptr_nxt != wr_commit_nxt);
  end
`endif

endmodule
